write_demux: RTL and testbench

WRITE_DEMUX -- requirements
Module: write_demux

---
 rtl/write_demux.sv | 101 ++++++++++
 tb/tb_write_demux.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/write_demux.sv
// Two-entry in-order FIFO that routes each {select, data} item to one of
// two output ports, with per-port delivery counters.
module write_demux #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] idata,
  input  logic             M1,
  input  logic             ivalid,
  output logic             iready,
  output logic [WIDTH-1:0] odata0,
  output logic             ovalid0,
  input  logic             oready0,
  output logic [WIDTH-1:0] odata1,
  output logic             ovalid1,
  input  logic             oready1,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1,
  output logic             busy
);

  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] cnt0_q, cnt0_d;
  logic [CNTW-1:0] cnt1_q, cnt1_d;

  logic [WIDTH-1:0] data_mem_q [2];
  logic             sel_mem_q  [2];

  logic             not_empty;
  logic             head_sel;
  logic [WIDTH-1:0] head_data;
  logic             push;
  logic             pop0;
  logic             pop1;
  logic             pop;

  // Everything outward-facing derives from registered state only.
  always_comb begin
    not_empty = (count_q != 2'd0);
    head_sel  = sel_mem_q[rd_ptr_q];
    head_data = data_mem_q[rd_ptr_q];
    iready    = (count_q != 2'd2);
    ovalid0   = not_empty && !head_sel;
    ovalid1   = not_empty && head_sel;
    odata0    = ovalid0 ? head_data : '0;
    odata1    = ovalid1 ? head_data : '0;
    busy      = not_empty;
    cnt0      = cnt0_q;
    cnt1      = cnt1_q;
  end

  always_comb begin
    push     = ivalid && iready;
    pop0     = ovalid0 && oready0;
    pop1     = ovalid1 && oready1;
    pop      = pop0 || pop1;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    if (pop0) cnt0_d = cnt0_q + CNTW'(1);
    if (pop1) cnt1_d = cnt1_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  // Storage is unreset; stale contents are hidden by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= idata;
      sel_mem_q[wr_ptr_q]  <= M1;
    end
  end

endmodule

// File: tb/tb_write_demux.sv
// Bench for write_demux: directed vector table plus a queue-based
// reference that is compared against the outputs every cycle.
module tb_write_demux;

  localparam int WIDTH = 32;
  localparam int CNTW  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] idata = '0;
  logic             M1 = 1'b0;
  logic             ivalid = 1'b0;
  logic             iready;
  logic [WIDTH-1:0] odata0;
  logic             ovalid0;
  logic             oready0 = 1'b0;
  logic [WIDTH-1:0] odata1;
  logic             ovalid1;
  logic             oready1 = 1'b0;
  logic [CNTW-1:0]  cnt0;
  logic [CNTW-1:0]  cnt1;
  logic             busy;

  write_demux #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .idata(idata), .M1(M1),
    .ivalid(ivalid), .iready(iready),
    .odata0(odata0), .ovalid0(ovalid0), .oready0(oready0),
    .odata1(odata1), .ovalid1(ovalid1), .oready1(oready1),
    .cnt0(cnt0), .cnt1(cnt1), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Reference: expected items queued when accepted, removed when delivered.
  typedef struct packed {
    logic             sel;
    logic [WIDTH-1:0] data;
  } item_t;

  item_t           sb[$];
  logic [CNTW-1:0] mc0 = '0;
  logic [CNTW-1:0] mc1 = '0;

  always @(posedge clk or negedge rst_n) begin
    int  n;
    bit  do_pop;
    bit  do_push;
    if (!rst_n) begin
      sb.delete();
      mc0 = '0;
      mc1 = '0;
    end else begin
      n = sb.size();
      do_pop  = (n > 0) && (sb[0].sel ? oready1 : oready0);
      do_push = ivalid && (n != 2);
      if (do_pop) begin
        if (sb[0].sel) mc1 = mc1 + CNTW'(1);
        else           mc0 = mc0 + CNTW'(1);
        void'(sb.pop_front());
      end
      if (do_push) sb.push_back('{sel: M1, data: idata});
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    logic             ev0;
    logic             ev1;
    logic [WIDTH-1:0] ed;
    if (chk_en && rst_n) begin
      ev0 = (sb.size() > 0) && !sb[0].sel;
      ev1 = (sb.size() > 0) && sb[0].sel;
      ed  = (sb.size() > 0) ? sb[0].data : '0;
      chk("sb_iready", 64'(iready), 64'(sb.size() != 2));
      chk("sb_busy", 64'(busy), 64'(sb.size() != 0));
      chk("sb_ovalid0", 64'(ovalid0), 64'(ev0));
      chk("sb_ovalid1", 64'(ovalid1), 64'(ev1));
      chk("sb_odata0", 64'(odata0), ev0 ? 64'(ed) : 64'd0);
      chk("sb_odata1", 64'(odata1), ev1 ? 64'(ed) : 64'd0);
      chk("sb_cnt0", 64'(cnt0), 64'(mc0));
      chk("sb_cnt1", 64'(cnt1), 64'(mc1));
    end
  end

  typedef struct {
    logic        iv;
    logic        m1;
    logic [31:0] d;
    logic        or0;
    logic        or1;
    logic        e_rdy;
    logic        e_v0;
    logic [31:0] e_d0;
    logic        e_v1;
    logic [31:0] e_d1;
    logic [15:0] e_c0;
    logic [15:0] e_c1;
    logic        e_busy;
  } vec_t;

  vec_t vt[11];

  task automatic drive(input logic iv, input logic m1, input logic [31:0] d,
                       input logic or0, input logic or1);
    @(posedge clk);
    #1;
    ivalid  = iv;
    M1      = m1;
    idata   = d;
    oready0 = or0;
    oready1 = or1;
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    ivalid  = 1'b0;
    oready0 = 1'b0;
    oready1 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    //        iv  m1  d             or0 or1 rdy v0  d0            v1  d1     c0  c1  busy
    vt[0]  = '{1, 0, 32'hDEADBEEF, 1, 0, 1, 0, 0,            0, 0,     0, 0, 0};
    vt[1]  = '{0, 0, 0,            1, 0, 1, 1, 32'hDEADBEEF, 0, 0,     0, 0, 1};
    vt[2]  = '{0, 0, 0,            0, 0, 1, 0, 0,            0, 0,     1, 0, 0};
    vt[3]  = '{1, 1, 32'h11,       0, 0, 1, 0, 0,            0, 0,     1, 0, 0};
    vt[4]  = '{1, 0, 32'h22,       0, 0, 1, 0, 0,            1, 32'h11, 1, 0, 1};
    vt[5]  = '{1, 0, 32'h33,       0, 0, 0, 0, 0,            1, 32'h11, 1, 0, 1};
    vt[6]  = '{0, 0, 0,            1, 0, 0, 0, 0,            1, 32'h11, 1, 0, 1};
    vt[7]  = '{0, 0, 0,            1, 1, 0, 0, 0,            1, 32'h11, 1, 0, 1};
    vt[8]  = '{0, 0, 0,            0, 0, 1, 1, 32'h22,       0, 0,     1, 1, 1};
    vt[9]  = '{0, 0, 0,            1, 0, 1, 1, 32'h22,       0, 0,     1, 1, 1};
    vt[10] = '{0, 0, 0,            0, 0, 1, 0, 0,            0, 0,     2, 1, 0};

    // Reset state, checked while clock still runs with rst_n low.
    @(negedge clk);
    chk("rst_iready", 64'(iready), 64'd1);
    chk("rst_ovalid0", 64'(ovalid0), 64'd0);
    chk("rst_ovalid1", 64'(ovalid1), 64'd0);
    chk("rst_odata0", 64'(odata0), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt0", 64'(cnt0), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].iv, vt[i].m1, vt[i].d, vt[i].or0, vt[i].or1);
      @(negedge clk);
      chk($sformatf("vec%0d_iready", i), 64'(iready), 64'(vt[i].e_rdy));
      chk($sformatf("vec%0d_ovalid0", i), 64'(ovalid0), 64'(vt[i].e_v0));
      chk($sformatf("vec%0d_odata0", i), 64'(odata0), 64'(vt[i].e_d0));
      chk($sformatf("vec%0d_ovalid1", i), 64'(ovalid1), 64'(vt[i].e_v1));
      chk($sformatf("vec%0d_odata1", i), 64'(odata1), 64'(vt[i].e_d1));
      chk($sformatf("vec%0d_cnt0", i), 64'(cnt0), 64'(vt[i].e_c0));
      chk($sformatf("vec%0d_cnt1", i), 64'(cnt1), 64'(vt[i].e_c1));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].e_busy));
    end

    // Streaming with alternating destinations.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, i[0], 32'h1000 + i, 1'b1, 1'b1);
      @(negedge clk);
      chk("stream_iready", 64'(iready), 64'd1);
      if (i > 0) chk("stream_one_per_cycle",
                     64'(ovalid0 | ovalid1), 64'd1);
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    @(negedge clk);
    chk("stream_cnt0", 64'(cnt0), 64'd50);
    chk("stream_cnt1", 64'(cnt1), 64'd50);

    // Async reset with two items held.
    drive(1'b1, 1'b0, 32'hAAAA, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'hBBBB, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_full", 64'(iready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ovalid0", 64'(ovalid0), 64'd0);
    chk("arst_ovalid1", 64'(ovalid1), 64'd0);
    chk("arst_iready", 64'(iready), 64'd1);
    chk("arst_cnt0", 64'(cnt0), 64'd0);
    chk("arst_cnt1", 64'(cnt1), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    oready0 = 1'b1;
    oready1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_v0", 64'(ovalid0), 64'd0);
    chk("post_rst_idle_cnt1", 64'(cnt1), 64'd0);

    // Counter wrap on port 0.
    do_reset();
    for (int i = 0; i < 65535; i++)
      drive(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("wrap_max", 64'(cnt0), 64'hFFFF);
    drive(1'b1, 1'b0, 32'h5A5A, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("wrap_zero", 64'(cnt0), 64'h0);
    chk("wrap_cnt1", 64'(cnt1), 64'h0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
